multicycle_datapath: RTL
========================

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter: WIDTH, 64, datapath/register/address width; legal values 32 or 64.
REQ-002 Parameter: RESET_PC, 0, PC value loaded at reset.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports: imem_req out 1 fetch request; imem_addr out WIDTH fetch byte address; imem_ack in 1 fetch complete; imem_rdata in 32 instruction word.
REQ-007 Ports: dmem_req out 1 data request; dmem_we out 1 write when 1; dmem_addr out WIDTH byte address; dmem_wdata out WIDTH store data; dmem_ack in 1 data complete; dmem_rdata in WIDTH load data.
REQ-008 Ports: pc out WIDTH current PC; retire out 1 one-cycle pulse per completed instruction; halt out 1 core stopped; fault out 2 halt cause (00 none, 01 illegal opcode, 10 misaligned data).

Function
REQ-009 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle except FETCH/MEM, which wait for ack.
REQ-010 Transfer completes on a rising edge where req&&ack; ack may arrive in the same cycle req rises (zero-wait); ack without req is ignored.
REQ-011 While req is high, addr/we/wdata hold stable; req stays high until transfer completes, then deasserts the following cycle.
REQ-012 FETCH: imem_addr=pc; on completion latch imem_rdata into IR, pc<=pc+4, go DECODE.
REQ-013 DECODE: read rs=IR[25:21], rt=IR[20:15+1] into A/B; sign-extend IR[15:0] to WIDTH; unsupported opcode/funct -> HALT, fault=01.
REQ-014 Supported: R-type (op 0) funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; bne 0x05; j 0x02.
REQ-015 Arithmetic modulo 2^WIDTH; no overflow trap; slt result 1 or 0 zero-extended.
REQ-016 EXEC: compute ALU result; beq/bne taken -> pc<=pc+(sext(imm)<<2); j -> pc<={pc[WIDTH-1:28],IR[25:0],2'b00}; branches/jump retire here and go FETCH.
REQ-017 lw/sw address = A+sext(imm); low log2(WIDTH/8) bits non-zero -> HALT, fault=10, no dmem_req issued.
REQ-018 MEM: lw reads full WIDTH word, sw writes B; sw retires on completion and goes FETCH; lw goes WB.
REQ-019 WB: R-type writes rd=IR[15:11]; addi/lw write rt; go FETCH and pulse retire.
REQ-020 Register file 32 x WIDTH; writes to r0 discarded; r0 always reads 0.
REQ-021 Cycle counts with zero-wait memory: branch/j 3, sw 4 (FETCH,DECODE,EXEC,MEM), R/addi 4 (FETCH,DECODE,EXEC,WB), lw 5; each wait cycle adds 1.
REQ-022 HALT is terminal until reset: req outputs 0, pc frozen, retire 0, fault held.
REQ-023 retire asserts for exactly one cycle, coincident with the architectural update becoming visible next edge.

Reset
REQ-024 rst_n low asynchronously forces: state FETCH, pc=RESET_PC, all 32 registers 0, imem_req=0, dmem_req=0, dmem_we=0, retire=0, halt=0, fault=00.
REQ-025 Reset mid-transaction drops req immediately; the aborted transfer has no architectural effect.
REQ-026 First imem_req asserts in the first clk cycle after rst_n rises, with imem_addr=RESET_PC.

Verification
REQ-027 Zero-wait: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 -> r3=2, three retire pulses 4 cycles apart, pc=RESET_PC+12.
REQ-028 Wait states: imem_ack delayed 3 cycles on fetch of sw r3,8(r0) -> imem_req/addr stable 4 cycles, dmem write addr 8 data 2, retire on dmem ack.
REQ-029 Branch: r1=r2, beq r1,r2,+2 at pc 0x20 -> pc=0x2C after 3 cycles; bne same operands -> pc=0x24.
REQ-030 Wrap/slt: WIDTH=64, r1=0x7FFF_FFFF_FFFF_FFFF, addi r2,r1,1 -> r2=0x8000_0000_0000_0000, fault=00; slt r3,r2,r1 -> r3=1.
REQ-031 Faults: lw r1,4(r0) with WIDTH=64 -> halt=1, fault=10, no dmem_req; opcode 0x3F -> halt=1, fault=01; add r0,r1,r1 -> r0 reads 0.
REQ-032 Reset: assert rst_n low while dmem_req high with dmem_ack low -> dmem_req=0 same cycle, pc=RESET_PC, registers 0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multicycle core for a small MIPS-like integer subset.
// Each instruction steps through FETCH, DECODE, EXEC, then MEM and/or WB.
// FETCH and MEM hold their request until the memory acknowledges it.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   imem_req/addr/ack/rdata    instruction fetch handshake (32-bit words)
//   dmem_req/we/addr/wdata/ack/rdata  data load/store handshake (WIDTH words)
//   pc                         current program counter
//   retire                     one-cycle pulse per completed instruction
//   halt, fault                core stopped; cause 01 illegal op, 10 misaligned
module multicycle_datapath #(
    parameter int unsigned      WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic             retire,
    output logic             halt,
    output logic [1:0]       fault
);

    localparam int unsigned      ALIGN_BITS = (WIDTH == 64) ? 3 : 2;
    localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'b100};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [31:0]      ir_q;
    logic [WIDTH-1:0] a_q, b_q, imm_q, alu_q;
    logic [WIDTH-1:0] rf_q [32];
    logic             imem_req_q, dmem_req_q, dmem_we_q;
    logic [WIDTH-1:0] dmem_addr_q, dmem_wdata_q;
    logic             retire_q, halt_q;
    logic [1:0]       fault_q;

    // Instruction fields (IR stays valid from DECODE through WB)
    logic [5:0]       op_s, funct_s;
    logic [4:0]       rs_s, rt_s, rd_s, dest_s;
    logic [WIDTH-1:0] sext_s;
    assign op_s    = ir_q[31:26];
    assign rs_s    = ir_q[25:21];
    assign rt_s    = ir_q[20:16];
    assign rd_s    = ir_q[15:11];
    assign funct_s = ir_q[5:0];
    assign sext_s  = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};

    logic is_r_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s, is_bne_s, is_j_s, illegal_s;

    // Opcode/funct decode into one-hot instruction classes
    always_comb begin
        is_r_s    = 1'b0;
        is_addi_s = 1'b0;
        is_lw_s   = 1'b0;
        is_sw_s   = 1'b0;
        is_beq_s  = 1'b0;
        is_bne_s  = 1'b0;
        is_j_s    = 1'b0;
        illegal_s = 1'b0;
        case (op_s)
            6'h00: begin
                is_r_s = 1'b1;
                case (funct_s)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: illegal_s = 1'b0;
                    default:                           illegal_s = 1'b1;
                endcase
            end
            6'h08:   is_addi_s = 1'b1;
            6'h23:   is_lw_s   = 1'b1;
            6'h2B:   is_sw_s   = 1'b1;
            6'h04:   is_beq_s  = 1'b1;
            6'h05:   is_bne_s  = 1'b1;
            6'h02:   is_j_s    = 1'b1;
            default: illegal_s = 1'b1;
        endcase
    end

    logic [WIDTH-1:0] alu_s;
    logic             slt_s;
    assign slt_s = ($signed(a_q) < $signed(b_q));

    // ALU: R-type uses A op B; addi and load/store addressing use A + sext(imm)
    always_comb begin
        alu_s = a_q + imm_q;
        if (is_r_s) begin
            case (funct_s)
                6'h20:   alu_s = a_q + b_q;
                6'h22:   alu_s = a_q - b_q;
                6'h24:   alu_s = a_q & b_q;
                6'h25:   alu_s = a_q | b_q;
                6'h2A:   alu_s = {{(WIDTH-1){1'b0}}, slt_s};
                default: alu_s = a_q + b_q;
            endcase
        end else begin
            alu_s = a_q + imm_q;
        end
    end

    logic             misaligned_s, br_taken_s, is_ctrl_s;
    logic [WIDTH-1:0] br_target_s, j_target_s;
    assign misaligned_s = |alu_s[ALIGN_BITS-1:0];
    assign br_taken_s   = (is_beq_s && (a_q == b_q)) || (is_bne_s && (a_q != b_q));
    assign is_ctrl_s    = is_beq_s || is_bne_s || is_j_s;
    // pc_q already points past the branch when these are used in EXEC
    assign br_target_s  = pc_q + {imm_q[WIDTH-3:0], 2'b00};
    assign j_target_s   = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
    assign dest_s       = is_r_s ? rd_s : rt_s;

    // Control FSM, datapath registers, register file and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= 32'h0000_0000;
            a_q          <= ZERO;
            b_q          <= ZERO;
            imm_q        <= ZERO;
            alu_q        <= ZERO;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= ZERO;
            dmem_wdata_q <= ZERO;
            retire_q     <= 1'b0;
            halt_q       <= 1'b0;
            fault_q      <= 2'b00;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= ZERO;
            end
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    // Request is raised on entry; only the first fetch after
                    // reset arrives here with it still low.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        pc_q       <= pc_q + PC_STEP;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    a_q   <= rf_q[rs_s];
                    b_q   <= rf_q[rt_s];
                    imm_q <= sext_s;
                    if (illegal_s) begin
                        halt_q  <= 1'b1;
                        fault_q <= 2'b01;
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_ctrl_s) begin
                        if (is_j_s) begin
                            pc_q <= j_target_s;
                        end else if (br_taken_s) begin
                            pc_q <= br_target_s;
                        end else begin
                            pc_q <= pc_q;
                        end
                        retire_q   <= 1'b1;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end else if (is_lw_s || is_sw_s) begin
                        if (misaligned_s) begin
                            halt_q  <= 1'b1;
                            fault_q <= 2'b10;
                            state_q <= S_HALT;
                        end else begin
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= is_sw_s;
                            dmem_addr_q  <= alu_s;
                            dmem_wdata_q <= b_q;
                            state_q      <= S_MEM;
                        end
                    end else begin
                        alu_q   <= alu_s;
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (dmem_we_q) begin
                            retire_q   <= 1'b1;
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end else begin
                            alu_q   <= dmem_rdata;
                            state_q <= S_WB;
                        end
                    end else begin
                        dmem_req_q <= 1'b1;
                    end
                end
                S_WB: begin
                    if (dest_s != 5'd0) begin
                        rf_q[dest_s] <= alu_q;
                    end
                    retire_q   <= 1'b1;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_HALT: begin
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                end
                default: begin
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    halt_q     <= 1'b1;
                    state_q    <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign pc         = pc_q;
    assign retire     = retire_q;
    assign halt       = halt_q;
    assign fault      = fault_q;

endmodule
